uart_bus_bridge: RTL and testbench



---
 rtl/uart_bus_bridge.sv | 182 ++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: 8N1 command frames on rx drive one 32-bit valid/ready bus access; ack/read data return on tx.
// Define UART_BRIDGE_WSTRB_EN to add a trailing write-strobe byte to write frames.
module uart_bus_bridge #(
    parameter int CLK_DIV       = 104,
    parameter int BUS_TIMEOUT   = 1024,
    parameter int FRAME_TIMEOUT = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic        valid,
    input  logic        ready,
    output logic [3:0]  wstrb,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(BUS_TIMEOUT + 1);
    localparam int FT = FRAME_TIMEOUT * CLK_DIV;
    localparam int FW = $clog2(FT + 1);
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_MID = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BUS_END = BW'(BUS_TIMEOUT - 1);
    localparam logic [FW-1:0] FT_END  = FW'(FT - 1);
    localparam logic [7:0]    ACK = 8'h06;
    localparam logic [7:0]    NAK = 8'h15;
`ifdef UART_BRIDGE_WSTRB_EN
    localparam logic [2:0]    DATA_END = 3'd4;
`else
    localparam logic [2:0]    DATA_END = 3'd3;
`endif

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS, RESP} state_t;
    state_t state, next;

    logic          rx_s1, rx_s2, rx_d, rx_busy, rx_done, rx_ferr;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic [3:0]    rx_bit, tx_bit;
    logic [7:0]    rx_sh;
    logic          is_write, tx_active, tx_last, tx_load, frame_to, bus_to, bad_strb;
    logic [2:0]    byte_cnt, resp_left;
    logic [BW-1:0] bus_cnt;
    logic [FW-1:0] ft_cnt;
    logic [31:0]   resp_sh;
    logic [9:0]    tx_frame;
    logic [3:0]    strb;

`ifdef UART_BRIDGE_WSTRB_EN
    assign bad_strb = rx_sh[3:0] == 4'h0;
    assign strb     = rx_sh[3:0];
`else
    assign bad_strb = 1'b0;
    assign strb     = 4'hF;
`endif

    // Receiver: bit 0 is the start bit, checked at half a bit time; bit 9 is the stop bit.
    always_ff @(posedge clk) begin
        rx_done <= 1'b0;
        rx_ferr <= 1'b0;
        if (reset) begin
            {rx_s1, rx_s2, rx_d} <= 3'b111;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            {rx_d, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
            if (!rx_busy) begin
                rx_cnt  <= '0;
                rx_bit  <= '0;
                rx_busy <= rx_d & ~rx_s2;
            end else if (rx_bit == 4'd0 ? rx_cnt == DIV_MID : rx_cnt == DIV_END) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0)
                    rx_busy <= ~rx_s2;
                else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_done <= rx_s2;
                    rx_ferr <= ~rx_s2;
                end else
                    rx_sh <= {rx_s2, rx_sh[7:1]};
            end else
                rx_cnt <= rx_cnt + CW'(1);
        end
    end

    assign frame_to = (state == GET_ADDR || state == GET_DATA) && ft_cnt == FT_END;
    assign bus_to   = state == BUS && bus_cnt == BUS_END && !ready;
    assign tx_last  = tx_active && tx_bit == 4'd9 && tx_cnt == DIV_END;
    assign tx_load  = state == RESP && resp_left != 3'd0 && (!tx_active || tx_last);
    assign valid    = state == BUS;
    assign busy     = state != IDLE;
    assign tx       = tx_frame[0];

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:     if (rx_done) next = (rx_sh == 8'h57 || rx_sh == 8'h52) ? GET_ADDR : RESP;
            GET_ADDR: if (rx_ferr || frame_to) next = IDLE;
                      else if (rx_done && byte_cnt == 3'd3) next = is_write ? GET_DATA : BUS;
            GET_DATA: if (rx_ferr || frame_to) next = IDLE;
                      else if (rx_done && byte_cnt == DATA_END) next = bad_strb ? RESP : BUS;
            BUS:      if (ready || bus_to) next = RESP;
            RESP:     if (tx_last && resp_left == 3'd0) next = IDLE;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            bus_cnt   <= '0;
            ft_cnt    <= '0;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            resp_sh   <= '0;
            resp_left <= '0;
        end else begin
            byte_cnt <= (next != state) ? 3'd0 : byte_cnt + {2'b0, rx_done};
            bus_cnt  <= (state == BUS) ? bus_cnt + BW'(1) : '0;
            ft_cnt   <= ((state == GET_ADDR || state == GET_DATA) && !rx_busy && !rx_done) ? ft_cnt + FW'(1) : '0;
            // Preload NAK so bad commands and rejected strobes need no extra path.
            if (state == IDLE && rx_done) begin
                is_write  <= rx_sh == 8'h57;
                wdata     <= '0;
                resp_sh   <= {NAK, 24'h0};
                resp_left <= 3'd1;
            end
            if (state == GET_ADDR && rx_done)
                addr <= {addr[23:0], rx_sh};
            if (state == GET_DATA && rx_done && byte_cnt != 3'd4)
                wdata <= {wdata[23:0], rx_sh};
            if (next == BUS && state != BUS)
                wstrb <= is_write ? strb : 4'h0;
            if (state == BUS && ready) begin
                resp_sh   <= is_write ? {ACK, 24'h0} : rdata;
                resp_left <= is_write ? 3'd1 : 3'd4;
            end else if (bus_to) begin
                resp_sh   <= {NAK, 24'h0};
                resp_left <= 3'd1;
            end else if (tx_load) begin
                resp_sh   <= {resp_sh[23:0], 8'h0};
                resp_left <= resp_left - 3'd1;
            end
        end
    end

    // Transmitter: tx_frame idles as all ones; reloading on the last stop cycle gives gapless bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_frame  <= '1;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
        end else if (tx_load) begin
            tx_frame  <= {1'b1, resp_sh[31:24], 1'b0};
            tx_active <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
        end else if (tx_active) begin
            tx_cnt <= (tx_cnt == DIV_END) ? '0 : tx_cnt + CW'(1);
            if (tx_cnt == DIV_END) begin
                tx_frame  <= {1'b1, tx_frame[9:1]};
                tx_bit    <= tx_bit + 4'd1;
                tx_active <= tx_bit != 4'd9;
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: table-driven frames plus hand-written sequences for timeouts, errors and reset.
module tb_uart_bus_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        tx, valid, busy;
    logic        ready = 1'b0;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic [31:0] rdata = 32'h0;

    uart_bus_bridge #(.CLK_DIV(16), .BUS_TIMEOUT(64), .FRAME_TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .valid(valid), .ready(ready),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef UART_BRIDGE_WSTRB_EN
    localparam int WN = 10;
`else
    localparam int WN = 9;
`endif

    typedef struct {
        logic [79:0] fr;
        int          nfr;
        int          dly;
        logic [31:0] rd;
        int          nacc;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          vc;
        int          nr;
        logic [31:0] rsp;
    } vec_t;

    vec_t v[12];
    int   nv = 0;
    int   n_chk = 0, n_err = 0, cur = 0;
    int   cyc = 0;
    int   rsp_delay = -1;
    logic [31:0] rsp_rdata = 32'h0;

    always @(posedge clk) cyc++;

    // Responder: ready comes rsp_delay cycles after valid rises (never if negative).
    int nacc = 0, vcyc = 0, unstable = 0, vcnt = 0;
    logic v_prev = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (!v_prev) begin
                nacc++;
                cap_addr = addr;
                cap_wdata = wdata;
                cap_wstrb = wstrb;
            end else if (addr !== cap_addr || wdata !== cap_wdata || wstrb !== cap_wstrb)
                unstable++;
            vcyc++;
            ready = (rsp_delay >= 0) && (vcnt >= rsp_delay);
            rdata = ready ? rsp_rdata : 32'h0;
            vcnt++;
        end else begin
            ready = 1'b0;
            rdata = 32'h0;
            vcnt = 0;
        end
        v_prev = (valid === 1'b1);
    end

    logic [7:0] txq[$];
    int         txst[$];
    int         tx_bad = 0;
    initial begin : txmon
        logic [7:0] b;
        int s;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                s = cyc;
                repeat (8) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = tx;
                end
                repeat (16) @(negedge clk);
                if (tx !== 1'b1) tx_bad++;
                txq.push_back(b);
                txst.push_back(s);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation ran past cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (case %0d): got %h, want %h", nm, cur, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [79:0] fr, input int n);
        for (int j = 0; j < n; j++) send_byte(fr[79-8*j -: 8], 1'b1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("busy_end", 32'(busy), 32'h0);
        repeat (24) @(negedge clk);
        chk("tx_idle", 32'(tx), 32'h1);
    endtask

    task automatic add(input logic [79:0] fr, input int nfr, input int dly, input logic [31:0] rd,
                       input int na, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int vc, input int nr, input logic [31:0] rsp);
        v[nv] = '{fr, nfr, dly, rd, na, a, wd, ws, vc, nr, rsp};
        nv++;
    endtask

    int b_nacc, b_vcyc, b_uns, b_tx;

    task automatic snap();
        b_nacc = nacc;
        b_vcyc = vcyc;
        b_uns = unstable;
        b_tx = txq.size();
    endtask

    task automatic chk_resp(input int nr, input logic [31:0] rsp);
        chk("resp_count", 32'(txq.size() - b_tx), 32'(nr));
        for (int k = 0; k < nr; k++)
            if (b_tx + k < txq.size()) chk("resp_byte", 32'(txq[b_tx+k]), 32'(rsp[31-8*k -: 8]));
        for (int k = 1; k < nr; k++)
            if (b_tx + k < txq.size()) chk("resp_gap", 32'(txst[b_tx+k] - txst[b_tx+k-1]), 32'd160);
    endtask

    initial begin
        add({8'h57, 32'h10000004, 32'hDEADBEEF, 8'h0F}, WN, 3, 32'h0, 1, 32'h10000004, 32'hDEADBEEF, 4'hF, 4, 1, 32'h06000000);
        add({8'h52, 32'h00000008, 40'h0}, 5, 0, 32'h12345678, 1, 32'h00000008, 32'h0, 4'h0, 1, 4, 32'h12345678);
        add({8'h52, 32'h0000000C, 40'h0}, 5, -1, 32'h0, 1, 32'h0000000C, 32'h0, 4'h0, 64, 1, 32'h15000000);
        add({8'h41, 72'h0}, 1, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h15000000);
        add({8'h57, 32'h00000003, 32'h01020304, 8'h0F}, WN, 1, 32'h0, 1, 32'h00000003, 32'h01020304, 4'hF, 2, 1, 32'h06000000);
        add({8'h52, 32'hABCDEF01, 40'h0}, 5, 2, 32'hA5A55A5A, 1, 32'hABCDEF01, 32'h0, 4'h0, 3, 4, 32'hA5A55A5A);
`ifdef UART_BRIDGE_WSTRB_EN
        add({8'h57, 32'h20000000, 32'h11223344, 8'h05}, 10, 0, 32'h0, 1, 32'h20000000, 32'h11223344, 4'h5, 1, 1, 32'h06000000);
        add({8'h57, 32'h20000000, 32'h11223344, 8'h00}, 10, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h15000000);
`endif

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_wstrb", 32'(wstrb), 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < nv; i++) begin
            cur = i;
            snap();
            rsp_delay = v[i].dly;
            rsp_rdata = v[i].rd;
            send_frame(v[i].fr, v[i].nfr);
            wait_idle();
            chk("access_count", 32'(nacc - b_nacc), 32'(v[i].nacc));
            if (v[i].nacc > 0) begin
                chk("addr", cap_addr, v[i].a);
                chk("wdata", cap_wdata, v[i].wd);
                chk("wstrb", 32'(cap_wstrb), 32'(v[i].ws));
                chk("valid_cycles", 32'(vcyc - b_vcyc), 32'(v[i].vc));
                chk("req_stable", 32'(unstable - b_uns), 32'h0);
            end
            chk_resp(v[i].nr, v[i].rsp);
        end

        // Partial frame left idle for 20 bit-times is dropped, then a clean read still works.
        cur = 100;
        snap();
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("ft_busy_mid", 32'(busy), 32'h1);
        repeat (290) @(negedge clk);
        chk("ft_busy_hold", 32'(busy), 32'h1);
        repeat (40) @(negedge clk);
        chk("ft_busy_drop", 32'(busy), 32'h0);
        chk("ft_no_access", 32'(nacc - b_nacc), 32'h0);
        chk("ft_no_tx", 32'(txq.size() - b_tx), 32'h0);
        snap();
        rsp_delay = 0;
        rsp_rdata = 32'hCAFEF00D;
        send_frame({8'h52, 32'h00000010, 40'h0}, 5);
        wait_idle();
        chk("ft_next_access", 32'(nacc - b_nacc), 32'h1);
        chk("ft_next_addr", cap_addr, 32'h00000010);
        chk_resp(4, 32'hCAFEF00D);

        // Stop bit low mid-frame drops the frame.
        cur = 101;
        snap();
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (40) @(negedge clk);
        chk("ferr_busy", 32'(busy), 32'h0);
        repeat (400) @(negedge clk);
        chk("ferr_no_access", 32'(nacc - b_nacc), 32'h0);
        chk("ferr_no_tx", 32'(txq.size() - b_tx), 32'h0);

        // Short low glitch must not look like a start bit.
        cur = 102;
        snap();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'h0);
        chk("glitch_no_tx", 32'(txq.size() - b_tx), 32'h0);

        // Reset two cycles into valid aborts the access with no response.
        cur = 103;
        snap();
        rsp_delay = -1;
        fork
            send_frame({8'h52, 32'h00000020, 40'h0}, 5);
        join_none
        begin
            int k = 0;
            while (valid !== 1'b1 && k < 2000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("rst_valid_seen", 32'(valid), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(valid), 32'h0);
        chk("rst_mid_tx", 32'(tx), 32'h1);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        wait fork;
        repeat (300) @(negedge clk);
        chk("rst_no_resp", 32'(txq.size() - b_tx), 32'h0);
        chk("rst_valid_cycles", 32'(vcyc - b_vcyc), 32'h2);
        chk("tx_stop_bits", 32'(tx_bad), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
